// File: rtl/cpu6502_branch_sequencer.sv
// PC sequencer for 6502 relative branches and JMP absolute; drives an external
// jump calculator and loads its newPC result each advancing cycle.
module cpu6502_branch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'hFFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   input  logic        pcLoad,
   input  logic [15:0] pcLoadValue,
   input  logic        branchStart,
   input  logic        jumpStart,
   input  logic        branchTaken,
   input  logic [7:0]  dataIn,
   input  logic [15:0] newPC,
   output logic [15:0] pc,
   output logic        increment,
   output logic        jumpRelative,
   output logic        jumpAbsolute,
   output logic [7:0]  relativeOffset,
   output logic [15:0] absoluteAddress,
   output logic        instrDone
);

   typedef enum logic [2:0] {
      FETCH,
      OPERAND,
      TAKEN,
      FIXUP,
      ADDRLO,
      ADDRHI
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc_next;
   logic [15:0] fixup_pc, fixup_next;
   logic [7:0]  low_byte, low_next;
   logic [7:0]  offset_next;
   logic        done_step;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= FETCH;
         pc             <= RESET_PC;
         relativeOffset <= '0;
         low_byte       <= '0;
         fixup_pc       <= '0;
      end else begin
         state          <= state_next;
         pc             <= pc_next;
         relativeOffset <= offset_next;
         low_byte       <= low_next;
         fixup_pc       <= fixup_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      offset_next  = relativeOffset;
      low_next     = low_byte;
      fixup_next   = fixup_pc;
      increment    = 1'b0;
      jumpRelative = 1'b0;
      jumpAbsolute = 1'b0;
      done_step    = 1'b0;

      case (state)
         FETCH: begin
            increment = 1'b1;
            pc_next   = newPC;
            if (jumpStart)        state_next = ADDRLO;
            else if (branchStart) state_next = OPERAND;
            else                  state_next = FETCH;
         end
         OPERAND: begin
            increment   = 1'b1;
            offset_next = dataIn;
            pc_next     = newPC;
            if (branchTaken) begin
               state_next = TAKEN;
            end else begin
               state_next = FETCH;
               done_step  = 1'b1;
            end
         end
         TAKEN: begin
            // Only the low byte moves now; the carried page arrives via FIXUP.
            jumpRelative = 1'b1;
            pc_next      = {pc[15:8], newPC[7:0]};
            fixup_next   = newPC;
            if (newPC[15:8] == pc[15:8]) begin
               state_next = FETCH;
               done_step  = 1'b1;
            end else begin
               state_next = FIXUP;
            end
         end
         FIXUP: begin
            pc_next    = fixup_pc;
            state_next = FETCH;
            done_step  = 1'b1;
         end
         ADDRLO: begin
            increment  = 1'b1;
            low_next   = dataIn;
            pc_next    = newPC;
            state_next = ADDRHI;
         end
         ADDRHI: begin
            jumpAbsolute = 1'b1;
            pc_next      = newPC;
            state_next   = FETCH;
            done_step    = 1'b1;
         end
         default: state_next = FETCH;
      endcase

      // pcLoad overrides the step regardless of advance; a stalled cycle holds everything.
      if (pcLoad) begin
         state_next  = FETCH;
         pc_next     = pcLoadValue;
         offset_next = relativeOffset;
         low_next    = low_byte;
         fixup_next  = fixup_pc;
      end else if (!advance) begin
         state_next  = state;
         pc_next     = pc;
         offset_next = relativeOffset;
         low_next    = low_byte;
         fixup_next  = fixup_pc;
      end

      instrDone = done_step & advance & ~pcLoad & ~reset;
   end

   assign absoluteAddress = {dataIn, low_byte};

endmodule

// File: tb/tb_cpu6502_branch_sequencer.sv
// Bench: acts as the jump calculator and checks each instruction against a
// per-instruction model of expected PC trace, controls and completion cycle.
module tb_cpu6502_branch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        advance;
   logic        pcLoad;
   logic [15:0] pcLoadValue;
   logic        branchStart;
   logic        jumpStart;
   logic        branchTaken;
   logic [7:0]  dataIn;
   logic [15:0] newPC;
   logic [15:0] pc;
   logic        increment;
   logic        jumpRelative;
   logic        jumpAbsolute;
   logic [7:0]  relativeOffset;
   logic [15:0] absoluteAddress;
   logic        instrDone;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_pc;

   always #5 clk = ~clk;

   cpu6502_branch_sequencer #(.RESET_PC(16'hFFFC)) dut (
      .clk(clk),
      .reset(reset),
      .advance(advance),
      .pcLoad(pcLoad),
      .pcLoadValue(pcLoadValue),
      .branchStart(branchStart),
      .jumpStart(jumpStart),
      .branchTaken(branchTaken),
      .dataIn(dataIn),
      .newPC(newPC),
      .pc(pc),
      .increment(increment),
      .jumpRelative(jumpRelative),
      .jumpAbsolute(jumpAbsolute),
      .relativeOffset(relativeOffset),
      .absoluteAddress(absoluteAddress),
      .instrDone(instrDone)
   );

   task automatic drive(input logic adv, input logic bs, input logic js, input logic bt,
                        input logic [7:0] din, input logic [15:0] npc);
      advance     = adv;
      branchStart = bs;
      jumpStart   = js;
      branchTaken = bt;
      dataIn      = din;
      newPC       = npc;
      pcLoad      = 1'b0;
      pcLoadValue = 16'($urandom);
   endtask

   task automatic load_pc(input logic [15:0] v);
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
      pcLoad      = 1'b1;
      pcLoadValue = v;
      #1;
      checks++;
      if (instrDone !== 1'b0) begin
         errors++;
         $display("FAIL load_done actual=%b required=0", instrDone);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc !== v) begin
         errors++;
         $display("FAIL load_pc actual=%h required=%h", pc, v);
      end
      pcLoad = 1'b0;
      m_pc   = v;
   endtask

   // kind: 0 plain opcode, 1 relative branch, 2 JMP absolute.
   // stall_mode: 0 none, 1 one stall before every cycle, 2 random stalls.
   task automatic run_instr(input int kind, input logic taken, input logic [7:0] b1,
                            input logic [7:0] b2, input logic both, input int stall_mode);
      logic [15:0] epc[4];
      logic [15:0] npc[4];
      logic [2:0]  ectl[4];
      logic [15:0] p, t, cur;
      int          n;
      int          nst;
      p = m_pc;
      n = 1;
      epc[0] = p + 16'd1;
      ectl[0] = 3'b100;
      if (kind == 1) begin
         epc[1]  = p + 16'd2;
         ectl[1] = 3'b100;
         n = 2;
         if (taken) begin
            t       = epc[1] + {{8{b1[7]}}, b1};
            epc[2]  = {epc[1][15:8], t[7:0]};
            ectl[2] = 3'b010;
            n = 3;
            if (t[15:8] != epc[1][15:8]) begin
               epc[3]  = t;
               ectl[3] = 3'b000;
               n = 4;
            end
         end
      end else if (kind == 2) begin
         epc[1]  = p + 16'd2;
         ectl[1] = 3'b100;
         epc[2]  = {b2, b1};
         ectl[2] = 3'b001;
         n = 3;
      end
      for (int i = 0; i < 4; i++) npc[i] = epc[i];
      if (kind == 1 && taken) npc[2] = t;
      if (n == 4) npc[3] = 16'($urandom);

      for (int i = 0; i < n; i++) begin
         cur = (i == 0) ? p : epc[i-1];
         nst = (stall_mode == 1) ? 1 :
               (stall_mode == 2 && $urandom_range(99) < 30) ? int'($urandom_range(2, 1)) : 0;
         for (int s = 0; s < nst; s++) begin
            @(negedge clk);
            drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 16'($urandom));
            #1;
            checks++;
            if ({increment, jumpRelative, jumpAbsolute} !== ectl[i] || instrDone !== 1'b0) begin
               errors++;
               $display("FAIL stall_ctl cycle=%0d actual=%b/%b required=%b/0",
                        i, {increment, jumpRelative, jumpAbsolute}, instrDone, ectl[i]);
            end
            if (kind == 1 && i == 2) begin
               checks++;
               if (relativeOffset !== b1) begin
                  errors++;
                  $display("FAIL stall_offset actual=%h required=%h", relativeOffset, b1);
               end
            end
            if (kind == 2 && i == 2) begin
               checks++;
               if (absoluteAddress[7:0] !== b1) begin
                  errors++;
                  $display("FAIL stall_lowbyte actual=%h required=%h", absoluteAddress[7:0], b1);
               end
            end
            @(posedge clk);
            #1;
            checks++;
            if (pc !== cur) begin
               errors++;
               $display("FAIL stall_pc cycle=%0d actual=%h required=%h", i, pc, cur);
            end
         end

         @(negedge clk);
         drive(1'b1,
               (i == 0) && (kind == 1 || (kind == 2 && both)),
               (i == 0) && (kind == 2),
               (i == 1) ? taken : 1'($urandom),
               (i == 1) ? b1 : (kind == 2 && i == 2) ? b2 : 8'($urandom),
               npc[i]);
         #1;
         checks++;
         if ({increment, jumpRelative, jumpAbsolute} !== ectl[i]) begin
            errors++;
            $display("FAIL ctl kind=%0d cycle=%0d actual=%b required=%b",
                     kind, i, {increment, jumpRelative, jumpAbsolute}, ectl[i]);
         end
         checks++;
         if (instrDone !== (kind != 0 && i == n - 1)) begin
            errors++;
            $display("FAIL done kind=%0d cycle=%0d actual=%b required=%b",
                     kind, i, instrDone, (kind != 0 && i == n - 1));
         end
         if (kind == 1 && i == 2) begin
            checks++;
            if (relativeOffset !== b1) begin
               errors++;
               $display("FAIL offset actual=%h required=%h", relativeOffset, b1);
            end
         end
         if (kind == 2 && i == 2) begin
            checks++;
            if (absoluteAddress !== {b2, b1}) begin
               errors++;
               $display("FAIL abs_addr actual=%h required=%h", absoluteAddress, {b2, b1});
            end
         end
         @(posedge clk);
         #1;
         checks++;
         if (pc !== epc[i]) begin
            errors++;
            $display("FAIL pc kind=%0d cycle=%0d actual=%h required=%h", kind, i, pc, epc[i]);
         end
      end
      m_pc = epc[n-1];
   endtask

   task automatic test_reset;
      reset = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 16'h1111);
      @(negedge clk);
      #1;
      checks++;
      if (pc !== 16'hFFFC) begin
         errors++;
         $display("FAIL reset_pc actual=%h required=fffc", pc);
      end
      checks++;
      if ({increment, jumpRelative, jumpAbsolute, instrDone} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctl actual=%b required=1000",
                  {increment, jumpRelative, jumpAbsolute, instrDone});
      end
      checks++;
      if (relativeOffset !== 8'h00 || absoluteAddress !== 16'hA500) begin
         errors++;
         $display("FAIL reset_latches actual=%h/%h required=00/a500", relativeOffset, absoluteAddress);
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc !== 16'hFFFC) begin
         errors++;
         $display("FAIL reset_hold_pc actual=%h required=fffc", pc);
      end
      @(negedge clk);
      reset = 1'b0;
      m_pc  = 16'hFFFC;
      run_instr(0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
   endtask

   task automatic test_directed_branches;
      load_pc(16'h1234);
      run_instr(1, 1'b0, 8'h10, 8'h00, 1'b0, 0);
      load_pc(16'h1234);
      run_instr(1, 1'b1, 8'h10, 8'h00, 1'b0, 0);
      run_instr(0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
      load_pc(16'h12F0);
      run_instr(1, 1'b1, 8'h20, 8'h00, 1'b0, 0);
      load_pc(16'h1205);
      run_instr(1, 1'b1, 8'hF0, 8'h00, 1'b0, 0);
   endtask

   task automatic test_jmp;
      load_pc(16'h8000);
      run_instr(2, 1'b0, 8'h34, 8'h12, 1'b0, 1);
      load_pc(16'h8000);
      run_instr(2, 1'b0, 8'h78, 8'h56, 1'b1, 0);
   endtask

   task automatic test_wrap;
      load_pc(16'hFFFF);
      run_instr(0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
      load_pc(16'hFFFB);
      run_instr(1, 1'b1, 8'h05, 8'h00, 1'b0, 1);
   endtask

   task automatic test_abort;
      load_pc(16'h1234);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom), 16'h1235);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 16'h1236);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 16'h11B6);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if (pc !== 16'hFFFC || {increment, jumpRelative, jumpAbsolute, instrDone} !== 4'b1000) begin
         errors++;
         $display("FAIL abort_reset actual=%h/%b required=fffc/1000",
                  pc, {increment, jumpRelative, jumpAbsolute, instrDone});
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc !== 16'hFFFC || relativeOffset !== 8'h00) begin
         errors++;
         $display("FAIL abort_hold actual=%h/%h required=fffc/00", pc, relativeOffset);
      end
      @(negedge clk);
      reset = 1'b0;
      m_pc  = 16'hFFFC;
      run_instr(0, 1'b0, 8'h00, 8'h00, 1'b0, 0);

      load_pc(16'h12F0);
      @(negedge clk); drive(1'b1, 1'b1, 1'b0, 1'b0, 8'($urandom), 16'h12F1);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 16'h12F2);
      @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 16'h1312);
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'($urandom), 16'($urandom));
      pcLoad      = 1'b1;
      pcLoadValue = 16'hC000;
      #1;
      checks++;
      if ({increment, jumpRelative, jumpAbsolute, instrDone} !== 4'b0000) begin
         errors++;
         $display("FAIL fixup_load_ctl actual=%b required=0000",
                  {increment, jumpRelative, jumpAbsolute, instrDone});
      end
      @(posedge clk);
      #1;
      checks++;
      if (pc !== 16'hC000) begin
         errors++;
         $display("FAIL fixup_load_pc actual=%h required=c000", pc);
      end
      pcLoad = 1'b0;
      m_pc   = 16'hC000;
      run_instr(0, 1'b0, 8'h00, 8'h00, 1'b0, 0);
   endtask

   task automatic test_random;
      for (int k = 0; k < 80; k++) begin
         if ($urandom_range(7) == 0) load_pc({8'hFF, 8'($urandom)});
         else if ($urandom_range(7) == 0) load_pc(16'($urandom));
         run_instr(int'($urandom_range(2)), 1'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom), 2);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset;
      test_directed_branches;
      test_jmp;
      test_wrap;
      test_abort;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
